// File: rtl/input_conditioner.sv
// input_conditioner
//   Multi-channel conditioner for mechanical inputs (buttons, switches).
//   Each channel: STAGES-deep flop synchroniser -> counter debouncer ->
//   registered edge detector. Channels share no state.
//
// Parameters
//   WIDTH            number of independent channels (>= 1)
//   STAGES           synchroniser depth per channel (>= 2)
//   DEBOUNCE_CYCLES  consecutive synchronised cycles a new value must hold
//                    before it is accepted (>= 1)
//
// Ports
//   clk    in   system clock, rising edge
//   rst    in   asynchronous active-high reset, clears all state
//   in     in   [WIDTH-1:0] raw asynchronous inputs
//   level  out  [WIDTH-1:0] debounced registered level
//   rise   out  [WIDTH-1:0] one-cycle pulse on accepted 0->1
//   fall   out  [WIDTH-1:0] one-cycle pulse on accepted 1->0
module input_conditioner #(
    parameter int WIDTH           = 4,
    parameter int STAGES          = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        logic [STAGES-1:0] sync;
        logic              s;
        logic [CW-1:0]     cnt;
        logic              lvl_q;
        logic              rise_q;
        logic              fall_q;

        // sync[0] takes the raw pin; higher indices are later stages.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync <= '0;
            end else begin
                sync <= {sync[STAGES-2:0], in[i]};
            end
        end

        assign s = sync[STAGES-1];

        // cnt counts consecutive cycles where s disagrees with the accepted
        // level; the DEBOUNCE_CYCLES-th such cycle commits the new value.
        // With DEBOUNCE_CYCLES=1, CNT_MAX is 0 and every change is taken at once.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt    <= '0;
                lvl_q  <= 1'b0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                if (s == lvl_q) begin
                    cnt <= '0;
                end else if (cnt == CNT_MAX) begin
                    cnt    <= '0;
                    lvl_q  <= s;
                    rise_q <= s;
                    fall_q <= ~s;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign level[i] = lvl_q;
        assign rise[i]  = rise_q;
        assign fall[i]  = fall_q;
    end

endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner
//   Self-checking bench for input_conditioner (WIDTH=4, STAGES=2,
//   DEBOUNCE_CYCLES=4). A reference model keeps the history of raw samples
//   and accepts a new level when the last DEBOUNCE_CYCLES synchronised
//   values all differ from the current level.
module tb_input_conditioner;

    localparam int WIDTH  = 4;
    localparam int STAGES = 2;
    localparam int DEB    = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] in_v = '0;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    input_conditioner #(
        .WIDTH(WIDTH),
        .STAGES(STAGES),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in(in_v),
        .level(level),
        .rise(rise),
        .fall(fall)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Raw input samples, one per rising edge since reset release.
    logic [WIDTH-1:0] smp[$];
    logic [WIDTH-1:0] m_level = '0;
    logic [WIDTH-1:0] m_rise  = '0;
    logic [WIDTH-1:0] m_fall  = '0;

    // Synchronised value presented to the debouncer at edge m (1-based):
    // the raw sample taken STAGES edges earlier, or 0 if none yet.
    function automatic logic seen(int m, int b);
        if (m - STAGES >= 1) return smp[m-STAGES-1][b];
        return 1'b0;
    endfunction

    // Advance one clock edge, update the model, leave time 1 unit after edge.
    task automatic step();
        int  n;
        bit  acc;
        @(posedge clk);
        if (rst) begin
            smp.delete();
            m_level = '0;
            m_rise  = '0;
            m_fall  = '0;
        end else begin
            smp.push_back(in_v);
            n = smp.size();
            m_rise = '0;
            m_fall = '0;
            for (int b = 0; b < WIDTH; b++) begin
                acc = 1'b1;
                for (int k = 0; k < DEB; k++) begin
                    if (seen(n - k, b) == m_level[b]) acc = 1'b0;
                end
                if (acc) begin
                    m_level[b] = ~m_level[b];
                    if (m_level[b]) m_rise[b] = 1'b1;
                    else            m_fall[b] = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic apply_reset();
        rst  = 1'b1;
        in_v = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({level, rise, fall} !== 12'h000) begin
            failures++;
            $display("FAIL reset_hold: got %h expected 000", {level, rise, fall});
        end
        apply_reset();
        for (int e = 0; e < 8; e++) begin
            step();
            checks++;
            if ({level, rise, fall} !== 12'h000) begin
                failures++;
                $display("FAIL reset_idle e=%0d: got %h expected 000", e, {level, rise, fall});
            end
        end
        in_v = 4'hF;
        for (int e = 0; e < 6; e++) step();
        checks++;
        if (level !== 4'hF || rise !== 4'hF) begin
            failures++;
            $display("FAIL pre_async_reset: level=%b rise=%b expected 1111/1111", level, rise);
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({level, rise, fall} !== 12'h000) begin
            failures++;
            $display("FAIL async_reset: got %h expected 000 before clock edge", {level, rise, fall});
        end
        step();
        in_v = '0;
        rst  = 1'b0;
    endtask

    task automatic test_rise_ch0();
        apply_reset();
        in_v = 4'b0001;
        for (int e = 1; e <= 9; e++) begin
            step();
            checks++;
            if ({level, rise, fall} !== {m_level, m_rise, m_fall}) begin
                failures++;
                $display("FAIL rise_ch0_model e=%0d: got %h expected %h", e,
                         {level, rise, fall}, {m_level, m_rise, m_fall});
            end
            if (e == 5 || e == 6 || e == 7) begin
                checks++;
                if (level !== ((e >= 6) ? 4'b0001 : 4'b0000) ||
                    rise !== ((e == 6) ? 4'b0001 : 4'b0000) || fall !== 4'b0000) begin
                    failures++;
                    $display("FAIL rise_ch0_edge%0d: level=%b rise=%b fall=%b", e, level, rise, fall);
                end
            end
        end
    endtask

    task automatic test_bounce();
        logic [5:0] pat;
        int         cnt_r;
        int         at_r;
        pat   = 6'b101101;   // pat[5] first: 1,0,1,1,0,1
        cnt_r = 0;
        at_r  = -1;
        apply_reset();
        for (int e = 1; e <= 16; e++) begin
            in_v[1] = (e <= 6) ? pat[6-e] : 1'b1;
            step();
            checks++;
            if ({level, rise, fall} !== {m_level, m_rise, m_fall}) begin
                failures++;
                $display("FAIL bounce_model e=%0d: got %h expected %h", e,
                         {level, rise, fall}, {m_level, m_rise, m_fall});
            end
            if (rise[1]) begin
                cnt_r++;
                at_r = e;
            end
        end
        checks++;
        if (cnt_r != 1 || at_r != 11) begin
            failures++;
            $display("FAIL bounce_pulse: rise count=%0d at edge %0d, expected 1 at edge 11", cnt_r, at_r);
        end
        in_v = '0;
    endtask

    task automatic test_min_width();
        int nr;
        int nf;
        int er;
        int ef;
        apply_reset();
        nr = 0;
        nf = 0;
        for (int e = 1; e <= 12; e++) begin
            in_v[2] = (e <= 3);
            step();
            checks++;
            if ({level, rise, fall} !== {m_level, m_rise, m_fall}) begin
                failures++;
                $display("FAIL short_model e=%0d: got %h expected %h", e,
                         {level, rise, fall}, {m_level, m_rise, m_fall});
            end
            if (rise[2]) nr++;
            if (fall[2] || level[2]) nf++;
        end
        checks++;
        if (nr != 0 || nf != 0) begin
            failures++;
            $display("FAIL short_reject: rise=%0d fall_or_level=%0d expected 0 0", nr, nf);
        end
        nr = 0; nf = 0; er = -1; ef = -1;
        for (int e = 1; e <= 14; e++) begin
            in_v[2] = (e <= 4);
            step();
            checks++;
            if ({level, rise, fall} !== {m_level, m_rise, m_fall}) begin
                failures++;
                $display("FAIL min_model e=%0d: got %h expected %h", e,
                         {level, rise, fall}, {m_level, m_rise, m_fall});
            end
            if (rise[2]) begin nr++; er = e; end
            if (fall[2]) begin nf++; ef = e; end
        end
        checks++;
        if (nr != 1 || nf != 1 || er != 6 || ef != 10) begin
            failures++;
            $display("FAIL min_accept: rise %0d@%0d fall %0d@%0d expected 1@6 1@10", nr, er, nf, ef);
        end
    endtask

    task automatic test_all_channels();
        apply_reset();
        for (int ph = 0; ph < 2; ph++) begin
            in_v = (ph == 0) ? 4'hF : 4'h0;
            for (int e = 1; e <= 9; e++) begin
                step();
                checks++;
                if ({level, rise, fall} !== {m_level, m_rise, m_fall}) begin
                    failures++;
                    $display("FAIL all_model ph=%0d e=%0d: got %h expected %h", ph, e,
                             {level, rise, fall}, {m_level, m_rise, m_fall});
                end
                if (e == 6) begin
                    checks++;
                    if ((ph == 0 && (rise !== 4'hF || level !== 4'hF || fall !== 4'h0)) ||
                        (ph == 1 && (fall !== 4'hF || level !== 4'h0 || rise !== 4'h0))) begin
                        failures++;
                        $display("FAIL all_edge ph=%0d: level=%b rise=%b fall=%b", ph, level, rise, fall);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_midcount();
        apply_reset();
        in_v = 4'b1000;
        for (int e = 1; e <= 4; e++) step();
        #3;
        rst = 1'b1;
        #1;
        for (int e = 0; e < 3; e++) begin
            checks++;
            if (level[3] !== 1'b0 || rise !== 4'h0 || fall !== 4'h0) begin
                failures++;
                $display("FAIL midcount_reset e=%0d: level=%b rise=%b fall=%b expected 0", e, level, rise, fall);
            end
            step();
        end
        rst = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step();
            checks++;
            if ({level, rise, fall} !== {m_level, m_rise, m_fall}) begin
                failures++;
                $display("FAIL midcount_model e=%0d: got %h expected %h", e,
                         {level, rise, fall}, {m_level, m_rise, m_fall});
            end
            if (e == 5 || e == 6) begin
                checks++;
                if (rise !== ((e == 6) ? 4'b1000 : 4'b0000)) begin
                    failures++;
                    $display("FAIL midcount_rise e=%0d: rise=%b", e, rise);
                end
            end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int e = 0; e < 400; e++) begin
            for (int b = 0; b < WIDTH; b++) begin
                if ($urandom_range(0, 5) == 0) in_v[b] = ~in_v[b];
            end
            step();
            checks++;
            if ({level, rise, fall} !== {m_level, m_rise, m_fall}) begin
                failures++;
                $display("FAIL random_model e=%0d: got %h expected %h", e,
                         {level, rise, fall}, {m_level, m_rise, m_fall});
            end
            checks++;
            if ((rise & fall) !== 4'h0) begin
                failures++;
                $display("FAIL random_exclusive e=%0d: rise=%b fall=%b", e, rise, fall);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rise_ch0();
        test_bounce();
        test_min_width();
        test_all_channels();
        test_reset_midcount();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Parametrised, multi-channel input conditioner for the mechanical inputs (push-buttons, switches) that feed the signed-multiplier datapath and control FSM. Each channel passes through a configurable-depth flip-flop synchroniser, then a counter-based debouncer, then an edge detector. The block produces a clean registered level and single-cycle rise/fall pulses per channel. It sits between the board pins and every consumer of user input; no consumer samples raw pins.

## Interface
- WIDTH, 4: number of independent channels (≥1).
- STAGES, 2: synchroniser flop depth per channel (≥2).
- DEBOUNCE_CYCLES, 4: consecutive synchronised cycles a new value must hold before it is accepted (≥1). Counter width is clog2(DEBOUNCE_CYCLES)+1.

- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset; clears all state immediately.
- in  input  WIDTH  raw asynchronous inputs, one bit per channel.
- level  output  WIDTH  debounced, registered level per channel.
- rise  output  WIDTH  one-cycle pulse when level goes 0→1.
- fall  output  WIDTH  one-cycle pulse when level goes 1→0.

## Operation
- Channels are fully independent; there is no shared state between bits.
- Sync chain: STAGES flops, sync[0] <= in[i], sync[k] <= sync[k-1]; s = sync[STAGES-1].
- Debouncer state per channel: counter cnt and accepted value level[i].
  - s == level[i]: cnt <= 0.
  - s != level[i] and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - s != level[i] and cnt == DEBOUNCE_CYCLES-1: level[i] <= s, cnt <= 0, and rise[i]/fall[i] <= 1 according to s (rise if s=1, fall if s=0).
- rise/fall are registered; both deassert on every edge where no acceptance occurs. rise[i] and fall[i] are never high together.
- Any disagreement shorter than DEBOUNCE_CYCLES cycles (glitch, bounce) resets cnt on its first agreeing cycle. level does not change and no pulse is produced.
- DEBOUNCE_CYCLES=1 degenerates to a pure synchroniser plus edge detector.

## Timing
- Reset (async assert, any time, including mid-count): all sync flops, cnt, level, rise and fall go to 0 without waiting for clk.
- After reset release with in[i] held at 1: level[i]=1 and rise[i]=1 for exactly one cycle, after STAGES+DEBOUNCE_CYCLES rising edges.
- Latency: a clean input change, held stable, appears on level (with its pulse in the same cycle) at the STAGES+DEBOUNCE_CYCLES-th rising edge after it is first sampled by sync[0].
- Minimum accepted pulse width at s is DEBOUNCE_CYCLES cycles. A width of DEBOUNCE_CYCLES-1 cycles is rejected.
- Back-to-back transitions: the earliest a second accepted change can occur is DEBOUNCE_CYCLES edges after the first. Pulses are therefore never adjacent when DEBOUNCE_CYCLES>1.
- Simultaneous changes on several channels each produce their own pulse in the same cycle.

## Test plan
- WIDTH=4, STAGES=2, DEBOUNCE_CYCLES=4. Apply rst, then in=4'b0000 -> level=0, rise=0, fall=0 throughout. Assert rst mid-operation -> all outputs 0 before the next clk edge.
- in[0] 0→1 held -> level[0]=1 and rise[0]=1 at edge 6 after first sample; rise[0]=0 at edge 7; other channels unaffected.
- in[1] bounce pattern 1,0,1,1,0,1 (1 cycle each), then steady 1 -> no pulse during bounce; a single rise[1] 6 edges after the final steady 1 is sampled.
- in[2] high for exactly 3 synchronised cycles, then low -> level[2] stays 0, no rise/fall. High for 4 cycles -> rise[2] fires, then fall[2] fires 4 edges after s returns low.
- in=4'b1111 at once from 0 -> rise=4'b1111 for one cycle, level=4'b1111. Then in=4'b0000 -> fall=4'b1111 one cycle.
- rst asserted at cnt=2 during a 0→1 change on in[3], released with in[3]=1 -> level[3]=0 during reset; rise[3] 6 edges after release.
